multiplexer_bus_arb: RTL and testbench
======================================

Name: multiplexer_bus_arb

Overview:
- Parametrised, registered N-input bus multiplexer with per-input valid/ready handshake and a one-entry output register.
- Selection is made by a built-in arbiter (fixed-priority or round-robin) or by an external select port.
- Sits between several bus producers (e.g. the core data port and debug/DMA masters) and a single downstream consumer in the MCU datapath.
- Supersedes the combinational 2-input bus multiplexer wherever back-pressure or fair sharing is needed.

Parameters:
- NrOfBits, 32, data width per input.
- NrOfInputs, 4, number of input channels, 2..16.
- SelBits, 2, width of Sel and OutChan; must equal ceil(log2(NrOfInputs)).
- Mode, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin, 2 = external Sel.

Ports:
- Clock, input, 1, rising-edge clock.
- nReset, input, 1, asynchronous active-low reset.
- Enable, input, 1, when 0 no new transfers are granted.
- MuxIn, input, NrOfInputs*NrOfBits, flattened input data; channel i occupies bits [i*NrOfBits +: NrOfBits].
- InValid, input, NrOfInputs, per-channel request/valid.
- InReady, output, NrOfInputs, per-channel accept (one-hot or zero).
- Sel, input, SelBits, channel select; used only in Mode 2.
- MuxOut, output, NrOfBits, registered selected data.
- OutValid, output, 1, MuxOut holds a valid word.
- OutReady, input, 1, downstream accepts MuxOut.
- OutChan, output, SelBits, index of the channel that supplied MuxOut.

Behaviour:
- Reset (nReset=0, asynchronous): MuxOut=0, OutValid=0, OutChan=0, round-robin pointer=0. InReady=0 while reset is asserted.
- Space: space = ~OutValid | OutReady. The output register may load in the same cycle it drains, so sustained throughput is 1 word per cycle.
- Grant g (combinational), evaluated only when Enable=1 and space=1:
  - Mode 0: lowest i with InValid[i]=1.
  - Mode 1: first i with InValid[i]=1, searching from pointer upward with wrap-around from NrOfInputs-1 to 0.
  - Mode 2: g=Sel, valid only if Sel<NrOfInputs and InValid[Sel]=1. Out-of-range Sel grants nothing.
- InReady[g]=1 for the granted channel only. All other InReady bits are 0. InReady is 0 whenever no grant exists.
- Transfer: a transfer occurs when InValid[g]=1 and InReady[g]=1. At the next rising edge:
  - MuxOut = MuxIn[g], OutChan = g, OutValid = 1.
  - Mode 1 only: pointer = (g+1) mod NrOfInputs.
- Latency: 1 cycle from input transfer to OutValid.
- Drain without refill: OutValid=1, OutReady=1 and no grant -> OutValid=0 next cycle. MuxOut and OutChan are cleared to 0 whenever OutValid falls.
- Stall: OutValid=1, OutReady=0 -> MuxOut, OutChan and OutValid hold, and InReady=0 for all channels.
- Enable=0: no new grants. A pending output word still drains normally via OutReady. Enable may change on any cycle; its effect on grants is immediate.
- Pointer behaviour: the pointer advances only on a transfer. In Modes 0 and 2 the pointer stays 0.
- Mid-operation reset: nReset asserted at any time clears the pending word. The discarded data is not replayed.
- Input contract: once InValid[i] is raised it must stay asserted, with stable data, until that channel's transfer. Behaviour is undefined if this is violated.

Test Plan:
- Reset and single transfer: reset with all inputs idle -> all outputs 0. Then Mode 1, InValid=4'b0100, MuxIn ch2=0xDEADBEEF, OutReady=1 -> InReady=4'b0100 the same cycle; next cycle MuxOut=0xDEADBEEF, OutChan=2, OutValid=1; pointer=3.
- Round-robin fairness: Mode 1, InValid=4'b1111 held, OutReady=1 -> OutChan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- Fixed priority: Mode 0, InValid=4'b1010 held, OutReady=1 -> OutChan=1 every cycle; channel 3 is never granted.
- Back-pressure: OutValid=1 with 0x11111111, OutReady=0 for 3 cycles while InValid=4'b0001 -> MuxOut holds 0x11111111 and InReady=0 for all 3 cycles. OutReady=1 -> load and drain occur in the same cycle; next cycle MuxOut=ch0 data.
- External select and Enable: Mode 2, NrOfInputs=3, Sel=3 -> no grant. Sel=1 with InValid[1]=1 and Enable=0 -> no grant. Raise Enable -> MuxOut=ch1 data next cycle.
- Asynchronous reset mid-stall: OutValid=1, OutReady=0, drop nReset between clock edges -> OutValid, MuxOut and OutChan go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multiplexer_bus_arb_if.sv
// Bus bundle for multiplexer_bus_arb: N producer channels in, one registered consumer port out.
// The arbiter side uses the slave modport; the producers/consumer side uses master.
interface multiplexer_bus_arb_if #(
  parameter int unsigned NrOfBits   = 32,
  parameter int unsigned NrOfInputs = 4,
  parameter int unsigned SelBits    = 2
) ();

  logic                             Enable;
  logic [NrOfInputs*NrOfBits-1:0]   MuxIn;
  logic [NrOfInputs-1:0]            InValid;
  logic [NrOfInputs-1:0]            InReady;
  logic [SelBits-1:0]               Sel;
  logic [NrOfBits-1:0]              MuxOut;
  logic                             OutValid;
  logic                             OutReady;
  logic [SelBits-1:0]               OutChan;

  modport slave (
    input  Enable,
    input  MuxIn,
    input  InValid,
    input  Sel,
    input  OutReady,
    output InReady,
    output MuxOut,
    output OutValid,
    output OutChan
  );

  modport master (
    output Enable,
    output MuxIn,
    output InValid,
    output Sel,
    output OutReady,
    input  InReady,
    input  MuxOut,
    input  OutValid,
    input  OutChan
  );

endinterface

// File: rtl/multiplexer_bus_arb.sv
// Registered N-input bus multiplexer with valid/ready handshake and a one-entry output register.
// Grant comes from fixed-priority, round-robin or external-select arbitration (Mode).
module multiplexer_bus_arb #(
  parameter int unsigned NrOfBits   = 32,
  parameter int unsigned NrOfInputs = 4,
  parameter int unsigned SelBits    = 2,
  parameter int unsigned Mode       = 1
) (
  input logic                  Clock,
  input logic                  nReset,
  multiplexer_bus_arb_if.slave bus
);

  localparam logic [SelBits-1:0] LastIdx = SelBits'(NrOfInputs - 1);

  logic [NrOfBits-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic [SelBits-1:0]    chan_q, chan_d;
  logic [SelBits-1:0]    ptr_q, ptr_d;

  logic                  space;
  logic                  gnt_valid;
  logic [SelBits-1:0]    gnt_idx;
  logic [NrOfBits-1:0]   gnt_data;
  logic [NrOfInputs-1:0] in_ready;

  // The output register may reload in the same cycle it drains.
  assign space = ~valid_q | bus.OutReady;

  always_comb begin
    int unsigned cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    unique case (Mode)
      0: begin
        // Descending scan so the lowest requesting index is written last.
        for (int i = NrOfInputs - 1; i >= 0; i--) begin
          if (bus.InValid[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SelBits'(i);
          end
        end
      end
      1: begin
        for (int unsigned k = 0; k < NrOfInputs; k++) begin
          cand = 32'(ptr_q) + k;
          if (cand >= NrOfInputs) cand = cand - NrOfInputs;
          if (!gnt_valid && bus.InValid[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SelBits'(cand);
          end
        end
      end
      default: begin
        // Out-of-range Sel matches no channel and therefore grants nothing.
        for (int unsigned i = 0; i < NrOfInputs; i++) begin
          if (bus.Sel == SelBits'(i) && bus.InValid[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = SelBits'(i);
          end
        end
      end
    endcase
    if (!(bus.Enable && space && nReset)) begin
      gnt_valid = 1'b0;
    end
  end

  always_comb begin
    gnt_data = '0;
    in_ready = '0;
    for (int unsigned i = 0; i < NrOfInputs; i++) begin
      if (gnt_idx == SelBits'(i)) begin
        gnt_data    = bus.MuxIn[i*NrOfBits +: NrOfBits];
        in_ready[i] = gnt_valid;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (gnt_valid) begin
      data_d  = gnt_data;
      valid_d = 1'b1;
      chan_d  = gnt_idx;
      if (Mode == 1) begin
        ptr_d = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
      end
    end else if (valid_q && bus.OutReady) begin
      data_d  = '0;
      valid_d = 1'b0;
      chan_d  = '0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.InReady  = in_ready;
  assign bus.MuxOut   = data_q;
  assign bus.OutValid = valid_q;
  assign bus.OutChan  = chan_q;

  a_ready_onehot0 : assert property (@(posedge Clock) disable iff (!nReset)
    $onehot0(bus.InReady));

  a_stall_hold : assert property (@(posedge Clock) disable iff (!nReset)
    (bus.OutValid && !bus.OutReady) |=> (bus.OutValid && $stable(bus.MuxOut)));

  a_ready_needs_space : assert property (@(posedge Clock) disable iff (!nReset)
    (|bus.InReady) |-> (space && bus.Enable));

endmodule

// File: tb/tb_multiplexer_bus_arb.sv
// Directed bench for multiplexer_bus_arb: one instance per arbitration mode sharing clock/reset.
module tb_multiplexer_bus_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multiplexer_bus_arb_if #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2)) if_rr ();
  multiplexer_bus_arb_if #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2)) if_fp ();
  multiplexer_bus_arb_if #(.NrOfBits(32), .NrOfInputs(3), .SelBits(2)) if_ex ();

  multiplexer_bus_arb #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2), .Mode(1)) u_rr (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (if_rr)
  );

  multiplexer_bus_arb #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2), .Mode(0)) u_fp (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (if_fp)
  );

  multiplexer_bus_arb #(.NrOfBits(32), .NrOfInputs(3), .SelBits(2), .Mode(2)) u_ex (
    .Clock  (clk),
    .nReset (rst_n),
    .bus    (if_ex)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if_rr.Enable = 1'b1; if_rr.MuxIn = '0; if_rr.InValid = 4'b0001; if_rr.Sel = '0;
    if_rr.OutReady = 1'b1;
    if_fp.Enable = 1'b1; if_fp.MuxIn = '0; if_fp.InValid = '0; if_fp.Sel = '0;
    if_fp.OutReady = 1'b1;
    if_ex.Enable = 1'b1; if_ex.MuxIn = '0; if_ex.InValid = '0; if_ex.Sel = '0;
    if_ex.OutReady = 1'b1;
    step();
    step();

    // Reset state; a request during reset must not be accepted.
    check_eq("rst_inready", 64'(if_rr.InReady), 64'h0);
    check_eq("rst_muxout", 64'(if_rr.MuxOut), 64'h0);
    check_eq("rst_outvalid", 64'(if_rr.OutValid), 64'h0);
    check_eq("rst_outchan", 64'(if_rr.OutChan), 64'h0);
    if_rr.InValid = '0;
    rst_n = 1'b1;
    step();
    check_eq("idle_outvalid", 64'(if_rr.OutValid), 64'h0);

    // Single transfer from channel 2.
    if_rr.MuxIn[2*32 +: 32] = 32'hDEADBEEF;
    if_rr.InValid = 4'b0100;
    #1;
    check_eq("t1_inready", 64'(if_rr.InReady), 64'h4);
    step();
    if_rr.InValid = 4'b0000;
    check_eq("t1_muxout", 64'(if_rr.MuxOut), 64'hDEADBEEF);
    check_eq("t1_outchan", 64'(if_rr.OutChan), 64'h2);
    check_eq("t1_outvalid", 64'(if_rr.OutValid), 64'h1);

    // Pointer is now 3: with all requesting, channel 3 goes first, then 0,1,2,3,0.
    for (int i = 0; i < 4; i++) if_rr.MuxIn[i*32 +: 32] = 32'hA0 + 32'(i);
    if_rr.InValid = 4'b1111;
    #1;
    check_eq("ptr3_inready", 64'(if_rr.InReady), 64'h8);
    step();
    check_eq("ptr3_outchan", 64'(if_rr.OutChan), 64'h3);
    for (int n = 0; n < 5; n++) begin
      step();
      check_eq($sformatf("rr_chan%0d", n), 64'(if_rr.OutChan), 64'(n % 4));
      check_eq($sformatf("rr_data%0d", n), 64'(if_rr.MuxOut), 64'(32'hA0 + 32'(n % 4)));
      check_eq($sformatf("rr_valid%0d", n), 64'(if_rr.OutValid), 64'h1);
    end
    if_rr.InValid = 4'b0000;
    step();
    check_eq("drain_valid", 64'(if_rr.OutValid), 64'h0);
    check_eq("drain_muxout", 64'(if_rr.MuxOut), 64'h0);
    check_eq("drain_chan", 64'(if_rr.OutChan), 64'h0);

    // Back-pressure with channel 0 (pointer is 1; wrap reaches 0).
    if_rr.MuxIn[0 +: 32] = 32'h11111111;
    if_rr.InValid = 4'b0001;
    step();
    check_eq("bp_load", 64'(if_rr.MuxOut), 64'h11111111);
    if_rr.OutReady = 1'b0;
    if_rr.MuxIn[0 +: 32] = 32'h22222222;
    for (int n = 0; n < 3; n++) begin
      #1;
      check_eq($sformatf("bp_inready%0d", n), 64'(if_rr.InReady), 64'h0);
      check_eq($sformatf("bp_hold%0d", n), 64'(if_rr.MuxOut), 64'h11111111);
      step();
    end
    check_eq("bp_still_valid", 64'(if_rr.OutValid), 64'h1);
    check_eq("bp_still_hold", 64'(if_rr.MuxOut), 64'h11111111);
    if_rr.OutReady = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(if_rr.InReady), 64'h1);
    step();
    if_rr.InValid = 4'b0000;
    check_eq("bp_reload", 64'(if_rr.MuxOut), 64'h22222222);
    check_eq("bp_reload_valid", 64'(if_rr.OutValid), 64'h1);
    step();
    check_eq("bp_drained", 64'(if_rr.OutValid), 64'h0);

    // Fixed priority: channel 1 always beats channel 3.
    if_fp.MuxIn[1*32 +: 32] = 32'h1;
    if_fp.MuxIn[3*32 +: 32] = 32'h3;
    if_fp.InValid = 4'b1010;
    #1;
    check_eq("fp_inready", 64'(if_fp.InReady), 64'h2);
    for (int n = 0; n < 4; n++) begin
      step();
      check_eq($sformatf("fp_chan%0d", n), 64'(if_fp.OutChan), 64'h1);
      check_eq($sformatf("fp_data%0d", n), 64'(if_fp.MuxOut), 64'h1);
      check_eq($sformatf("fp_ready%0d", n), 64'(if_fp.InReady), 64'h2);
    end
    if_fp.InValid = 4'b0000;
    step();
    check_eq("fp_drain", 64'(if_fp.OutValid), 64'h0);

    // External select with 3 inputs: Sel=3 is out of range.
    if_ex.MuxIn[1*32 +: 32] = 32'h55;
    if_ex.InValid = 3'b111;
    if_ex.Sel = 2'd3;
    #1;
    check_eq("ex_sel3_ready", 64'(if_ex.InReady), 64'h0);
    step();
    check_eq("ex_sel3_valid", 64'(if_ex.OutValid), 64'h0);
    if_ex.Sel = 2'd1;
    if_ex.InValid = 3'b010;
    if_ex.Enable = 1'b0;
    #1;
    check_eq("ex_dis_ready", 64'(if_ex.InReady), 64'h0);
    step();
    check_eq("ex_dis_valid", 64'(if_ex.OutValid), 64'h0);
    if_ex.Enable = 1'b1;
    #1;
    check_eq("ex_en_ready", 64'(if_ex.InReady), 64'h2);
    step();
    if_ex.InValid = 3'b000;
    check_eq("ex_muxout", 64'(if_ex.MuxOut), 64'h55);
    check_eq("ex_outchan", 64'(if_ex.OutChan), 64'h1);
    check_eq("ex_outvalid", 64'(if_ex.OutValid), 64'h1);

    // Asynchronous reset while stalled: outputs clear before any clock edge.
    if_rr.MuxIn[0 +: 32] = 32'h33333333;
    if_rr.InValid = 4'b0001;
    step();
    if_rr.InValid = 4'b0000;
    if_rr.OutReady = 1'b0;
    step();
    check_eq("ar_pre_valid", 64'(if_rr.OutValid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid", 64'(if_rr.OutValid), 64'h0);
    check_eq("ar_muxout", 64'(if_rr.MuxOut), 64'h0);
    check_eq("ar_outchan", 64'(if_rr.OutChan), 64'h0);
    step();
    rst_n = 1'b1;
    if_rr.OutReady = 1'b1;
    step();
    check_eq("ar_no_replay", 64'(if_rr.OutValid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
